// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX resolve and redirect/stat bundle shared
// between the branch predictor and the pipeline around it.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] ex_pc_plus4;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [15:0]     branch_cnt;
    logic [15:0]     mispredict_cnt;

    modport master (
        output if_valid, if_pc,
        output ex_valid, ex_pc, ex_taken, ex_pred_taken,
        output ex_target, ex_pc_plus4,
        input  pred_taken, redirect, redirect_pc, flush,
        input  branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_valid, if_pc,
        input  ex_valid, ex_pc, ex_taken, ex_pred_taken,
        input  ex_target, ex_pc_plus4,
        output pred_taken, redirect, redirect_pc, flush,
        output branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit counter predictor with registered mispredict
// redirect/flush and saturating branch statistics.
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int XLEN     = 32
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << IDX_BITS;

    logic [1:0]          tbl [DEPTH];
    logic                redirect_q;
    logic [XLEN-1:0]     redirect_pc_q;
    logic [15:0]         bcnt_q;
    logic [15:0]         mcnt_q;

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic                accept;
    logic                mispredict;
    logic [1:0]          cur;
    logic [1:0]          nxt;

    assign if_idx = bp.if_pc[IDX_BITS+1:2];
    assign ex_idx = bp.ex_pc[IDX_BITS+1:2];

    // Wrong-path branches behind a pending redirect are dropped.
    assign accept     = bp.ex_valid & ~redirect_q;
    assign mispredict = accept & (bp.ex_taken ^ bp.ex_pred_taken);
    assign cur        = tbl[ex_idx];

    always_comb begin
        nxt = cur;
        unique case (1'b1)
            bp.ex_taken && cur != 2'b11:  nxt = cur + 2'b01;
            !bp.ex_taken && cur != 2'b00: nxt = cur - 2'b01;
            default:                      nxt = cur;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= 2'b01;
            end
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            bcnt_q        <= '0;
            mcnt_q        <= '0;
        end else begin
            redirect_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= bp.ex_taken ? bp.ex_target
                                             : bp.ex_pc_plus4;
                if (mcnt_q != 16'hFFFF) begin
                    mcnt_q <= mcnt_q + 16'd1;
                end
            end
            if (accept) begin
                tbl[ex_idx] <= nxt;
                if (bcnt_q != 16'hFFFF) begin
                    bcnt_q <= bcnt_q + 16'd1;
                end
            end
        end
    end

    assign bp.pred_taken     = bp.if_valid & tbl[if_idx][1];
    assign bp.redirect       = redirect_q;
    assign bp.flush          = redirect_q;
    assign bp.redirect_pc    = redirect_pc_q;
    assign bp.branch_cnt     = bcnt_q;
    assign bp.mispredict_cnt = mcnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed and random checks of branch_predictor against a
// behavioural table/counter model.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    int          m_tab [16];
    int          m_b;
    int          m_m;
    bit          m_red;
    logic [31:0] m_rpc;

    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bp ();

    branch_predictor #(.IDX_BITS(4), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_tab[i] = 1;
        m_b = 0;
        m_m = 0;
        m_red = 0;
        m_rpc = 32'h0;
    endfunction

    function automatic void model_edge();
        bit acc;
        bit mis;
        int k;
        acc = bp.ex_valid && !m_red;
        mis = acc && (bp.ex_taken != bp.ex_pred_taken);
        if (acc) begin
            k = idx(bp.ex_pc);
            if (bp.ex_taken) m_tab[k] = (m_tab[k] < 3) ? m_tab[k] + 1 : 3;
            else m_tab[k] = (m_tab[k] > 0) ? m_tab[k] - 1 : 0;
            m_b = (m_b < 65535) ? m_b + 1 : 65535;
        end
        if (mis) begin
            m_m = (m_m < 65535) ? m_m + 1 : 65535;
            m_rpc = bp.ex_taken ? bp.ex_target : bp.ex_pc_plus4;
        end
        m_red = mis;
    endfunction

    task automatic drive(input bit iv, input logic [31:0] ipc,
                         input bit ev, input logic [31:0] epc,
                         input bit t, input bit pt);
        bp.if_valid = iv;
        bp.if_pc = ipc;
        bp.ex_valid = ev;
        bp.ex_pc = epc;
        bp.ex_taken = t;
        bp.ex_pred_taken = pt;
        bp.ex_target = epc + 32'h0C0;
        bp.ex_pc_plus4 = epc + 32'd4;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".redirect"}, 32'(bp.redirect), 32'(m_red));
        chk({tag, ".flush"}, 32'(bp.flush), 32'(m_red));
        chk({tag, ".rpc"}, bp.redirect_pc, m_rpc);
        chk({tag, ".bcnt"}, 32'(bp.branch_cnt), 32'(m_b));
        chk({tag, ".mcnt"}, 32'(bp.mispredict_cnt), 32'(m_m));
    endtask

    // Inputs are already applied at a negedge when this is called.
    task automatic step(input string tag);
        #1;
        chk({tag, ".pred"}, 32'(bp.pred_taken),
            32'(bp.if_valid && m_tab[idx(bp.if_pc)] >= 2));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs(tag);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        check_regs("rst");

        drive(1, 32'h40, 0, 0, 0, 0);
        step("init");
        chk("init.pred0", 32'(bp.pred_taken), 32'd0);

        drive(1, 32'h40, 1, 32'h40, 1, 0);
        step("mis1");
        chk("mis1.rpc100", bp.redirect_pc, 32'h100);
        chk("mis1.redir", 32'(bp.redirect), 32'd1);
        drive(1, 32'h40, 0, 0, 0, 0);
        step("after1");
        chk("after1.pred1", 32'(bp.pred_taken), 32'd1);

        repeat (3) begin
            drive(1, 32'h40, 1, 32'h40, 1, 1);
            step("sat");
        end
        chk("sat.entry", 32'(m_tab[idx(32'h40)]), 32'd3);
        drive(1, 32'h40, 1, 32'h40, 0, 1);
        step("nt");
        chk("nt.rpc44", bp.redirect_pc, 32'h44);
        drive(1, 32'h40, 0, 0, 0, 0);
        step("nt2");
        chk("nt2.pred", 32'(bp.pred_taken), 32'd1);

        drive(1, 32'h10, 1, 32'h10, 1, 0);
        step("b2b0");
        drive(1, 32'h10, 1, 32'h14, 0, 1);
        step("b2b1");
        chk("b2b1.noredir", 32'(bp.redirect), 32'd0);
        drive(1, 32'h10, 1, 32'h18, 1, 0);
        step("b2b2");
        drive(0, 0, 0, 0, 0, 0);
        step("b2b3");

        drive(1, 32'h80, 1, 32'h40, 0, 0);
        step("alias0");
        drive(1, 32'h80, 0, 0, 0, 0);
        step("alias1");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ep;
            ep = 32'($urandom_range(0, 7)) << 2;
            drive(1'($urandom), 32'($urandom_range(0, 63)) << 2,
                  1'($urandom), ep, 1'($urandom), 1'($urandom));
            step("rand");
        end

        drive(1, 32'h40, 1, 32'h40, 0, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("arst1");
        chk("arst1.pred", 32'(bp.pred_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h40, 1, 32'h40, 1, 0);
        step("arst2a");
        chk("arst2a.redir", 32'(bp.redirect), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("arst2");
        drive(1, 32'h40, 0, 0, 0, 0);
        #1;
        chk("arst2.pred", 32'(bp.pred_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("arst3");

        drive(0, 0, 1, 32'h20, 1, 1);
        repeat (65540) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        check_regs("satb");
        chk("satb.ffff", 32'(bp.branch_cnt), 32'hFFFF);
        step("satb2");
        chk("satb2.ffff", 32'(bp.branch_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
